// File: rtl/dma_stream_xform.sv
// DMA-side streaming transform: pops the read FIFO, adds a latched constant over a
// 2-stage pipeline and drains results into the write FIFO through a credited buffer.
module dma_stream_xform #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic [ADDR_WIDTH:0]   size,
    input  logic [ADDR_WIDTH-1:0] rd_base,
    input  logic [ADDR_WIDTH-1:0] wr_base,
    input  logic [DATA_WIDTH-1:0] addend,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_go,
    output logic                  wr_go,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   rd_size,
    output logic [ADDR_WIDTH:0]   wr_size,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  empty,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  full,
    input  logic                  wr_done
);
    localparam int PW    = $clog2(BUF_DEPTH);
    localparam int CW    = PW + 1;
    localparam int OW    = CW + 1;
    localparam int CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, START, RUN, WAIT, DONE} state_t;

    state_t                state, state_nx;
    logic                  accept;
    logic [ADDR_WIDTH:0]   size_q, rd_count, wr_count;
    logic [DATA_WIDTH-1:0] addend_q, s1_data, s2_data;
    logic [2:1]            vld_pipe;
    logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [PW-1:0]         wptr, rptr;
    logic [CW-1:0]         buf_count;
    logic [OW-1:0]         occupancy;

    assign accept = go && (state == IDLE || state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        rd_go    = 1'b0;
        wr_go    = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (go) state_nx = (size == '0) ? DONE : START;
            end
            START: begin
                busy     = 1'b1;
                rd_go    = 1'b1;
                wr_go    = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (wr_count == size_q) state_nx = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (wr_done) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Words already in the pipe hold a buffer credit, so admission never overfills it.
    assign occupancy = OW'(buf_count) + OW'(vld_pipe[1]) + OW'(vld_pipe[2]);
    assign rd_en     = (state == RUN) && !empty && (rd_count < size_q) &&
                       (occupancy < OW'(BUF_DEPTH));
    assign wr_en     = (buf_count != '0) && !full;
    assign wr_data   = (buf_count != '0) ? buf_mem[rptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q    <= '0;
            addend_q  <= '0;
            rd_addr   <= '0;
            wr_addr   <= '0;
            rd_size   <= '0;
            wr_size   <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
            vld_pipe  <= '0;
            s1_data   <= '0;
            s2_data   <= '0;
            wptr      <= '0;
            rptr      <= '0;
            buf_count <= '0;
        end else begin
            if (accept) begin
                size_q   <= size;
                addend_q <= addend;
                rd_addr  <= rd_base;
                wr_addr  <= wr_base;
                rd_size  <= size;
                wr_size  <= size;
                rd_count <= '0;
                wr_count <= '0;
            end else begin
                if (rd_en) rd_count <= rd_count + CNT_W'(1);
                if (wr_en) wr_count <= wr_count + CNT_W'(1);
            end
            vld_pipe <= {vld_pipe[1], rd_en};
            s1_data  <= rd_data;
            s2_data  <= s1_data + addend_q;
            if (vld_pipe[2]) wptr <= wptr + PW'(1);
            if (wr_en)       rptr <= rptr + PW'(1);
            case ({vld_pipe[2], wr_en})
                2'b10:   buf_count <= buf_count + CW'(1);
                2'b01:   buf_count <= buf_count - CW'(1);
                default: buf_count <= buf_count;
            endcase
        end
    end

    // Storage only; occupancy is tracked by buf_count, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (vld_pipe[2]) buf_mem[wptr] <= s2_data;
    end
endmodule
